// File: rtl/noc_packet_injector_if.sv
// Local-port link of noc_packet_injector: core word stream in, router flit stream out.
// slave is the injector's view; master is the attached core/router environment.
interface noc_packet_injector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COORD_W    = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic [COORD_W-1:0]    in_dest_x;
    logic [COORD_W-1:0]    in_dest_y;

    logic                  sender_valid;
    logic                  sender_ready;
    logic [DATA_WIDTH-1:0] sender_flit;
    logic                  sender_is_header;
    logic                  sender_is_tail;

    modport master (
        output in_valid, in_data, in_last, in_dest_x, in_dest_y, sender_ready,
        input  in_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );

    modport slave (
        input  in_valid, in_data, in_last, in_dest_x, in_dest_y, sender_ready,
        output in_ready, sender_valid, sender_flit, sender_is_header, sender_is_tail
    );
endinterface

// File: rtl/noc_packet_injector.sv
// Network interface in front of a mesh router local port: buffers core words, emits header/body/tail flits.
// Optional store-and-forward with header length field: define NOC_INJ_LEN_FIELD_EN.
module noc_packet_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int COORD_W    = 4,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst_n,
    noc_packet_injector_if.slave bus,
    output logic [7:0]           sent_pkt_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  first;
        logic [COORD_W-1:0]    dest_x;
        logic [COORD_W-1:0]    dest_y;
    } entry_t;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    entry_t                mem [FIFO_DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    ptr_t                  nxt_ptr;
    cnt_t                  count;
    logic                  expect_first;
    logic [COORD_W-1:0]    dest_x_q;
    logic [COORD_W-1:0]    dest_y_q;

    state_t                state;
    logic                  valid_q;
    logic                  is_header_q;
    logic                  is_tail_q;
    logic [DATA_WIDTH-1:0] flit_q;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    entry_t                head;
    entry_t                wr_entry;
    logic                  release_hdr;
    logic [7:0]            hdr_len;
    logic [DATA_WIDTH-1:0] hdr_flit;

    assign full          = (count == cnt_t'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign bus.in_ready  = noc_rst_n && !full;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = (state == BODY) && valid_q && bus.sender_ready;
    assign head          = mem[rd_ptr];
    assign nxt_ptr       = rd_ptr + ptr_t'(1);

    assign bus.sender_valid     = valid_q;
    assign bus.sender_flit      = flit_q;
    assign bus.sender_is_header = is_header_q;
    assign bus.sender_is_tail   = is_tail_q;

    // Destination is taken live on a packet's first word, from the latch afterwards.
    always_comb begin
        wr_entry.data   = bus.in_data;
        wr_entry.last   = bus.in_last;
        wr_entry.first  = expect_first;
        wr_entry.dest_x = expect_first ? bus.in_dest_x : dest_x_q;
        wr_entry.dest_y = expect_first ? bus.in_dest_y : dest_y_q;
    end

    // NOTE: payload storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge noc_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            expect_first <= 1'b1;
            dest_x_q     <= '0;
            dest_y_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + ptr_t'(1);
                expect_first <= bus.in_last;
                if (expect_first) begin
                    dest_x_q <= bus.in_dest_x;
                    dest_y_q <= bus.in_dest_y;
                end
            end
            if (pop) begin
                rd_ptr <= nxt_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        release_hdr = 1'b0;
        hdr_len     = '0;
        hdr_flit    = '0;
`ifdef NOC_INJ_LEN_FIELD_EN
        begin : scan_last
            logic found;
            ptr_t idx;
            found = 1'b0;
            idx   = '0;
            // The head is this packet's first word, so the first last-marker found ends it.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx = rd_ptr + ptr_t'(i);
                if (!found && (cnt_t'(i) < count) && mem[idx].last) begin
                    found   = 1'b1;
                    hdr_len = 8'(i + 1);
                end
            end
            release_hdr = head.first && (found || full);
        end
`else
        release_hdr = head.first && !empty;
`endif
        hdr_flit[COORD_W-1:0]           = head.dest_x;
        hdr_flit[2*COORD_W-1:COORD_W]   = head.dest_y;
        hdr_flit[3*COORD_W-1:2*COORD_W] = COORD_W'(X_ID);
        hdr_flit[4*COORD_W-1:3*COORD_W] = COORD_W'(Y_ID);
        hdr_flit[DATA_WIDTH-1 -: 8]     = hdr_len;
    end

    // Flit registers load only when the slot is empty or being accepted, which keeps them stable under backpressure.
    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state        <= IDLE;
            valid_q      <= 1'b0;
            is_header_q  <= 1'b0;
            is_tail_q    <= 1'b0;
            flit_q       <= '0;
            sent_pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (release_hdr) begin
                        flit_q      <= hdr_flit;
                        valid_q     <= 1'b1;
                        is_header_q <= 1'b1;
                        is_tail_q   <= 1'b0;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (!valid_q || bus.sender_ready) begin
                        if (!empty) begin
                            flit_q      <= head.data;
                            is_header_q <= 1'b0;
                            is_tail_q   <= head.last;
                            valid_q     <= 1'b1;
                            state       <= BODY;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                end
                BODY: begin
                    if (pop) begin
                        if (head.last) begin
                            sent_pkt_cnt <= sent_pkt_cnt + 8'd1;
                            valid_q      <= 1'b0;
                            is_tail_q    <= 1'b0;
                            state        <= IDLE;
                        end else if (count > cnt_t'(1)) begin
                            flit_q    <= mem[nxt_ptr].data;
                            is_tail_q <= mem[nxt_ptr].last;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end else if (!valid_q && !empty) begin
                        flit_q    <= head.data;
                        is_tail_q <= head.last;
                        valid_q   <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector: directed scenarios plus randomized traffic
// against a packet-level reference model (optionally built with NOC_INJ_LEN_FIELD_EN).
module tb_noc_packet_injector;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int XID   = 3;
    localparam int YID   = 6;
    localparam int DEPTH = 8;

    logic       noc_clk   = 1'b0;
    logic       noc_rst_n = 1'b0;
    logic [7:0] sent_pkt_cnt;

    noc_packet_injector_if #(.DATA_WIDTH(DW), .COORD_W(CW)) bus ();

    noc_packet_injector #(
        .DATA_WIDTH(DW), .COORD_W(CW), .X_ID(XID), .Y_ID(YID), .FIFO_DEPTH(DEPTH)
    ) dut (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .bus         (bus),
        .sent_pkt_cnt(sent_pkt_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: packets as seen by the core, and the words still owed to the router.
    typedef struct { logic [CW-1:0] dx; logic [CW-1:0] dy; int nwords; bit done; } pkt_t;
    typedef struct { logic [DW-1:0] data; bit last; } word_t;

    pkt_t       pkt_q[$];
    word_t      word_q[$];
    int         occ       = 0;
    bit         in_pkt    = 0;
    bit         hdr_done  = 0;
    logic [7:0] exp_cnt   = '0;
    bit         hold      = 0;
    logic [DW-1:0] hold_flit;
    logic       hold_hdr, hold_tail;
    bit         rst_prev  = 1;

    function automatic logic [DW-1:0] exp_header(input pkt_t p);
        logic [7:0] len;
        len = '0;
`ifdef NOC_INJ_LEN_FIELD_EN
        if (p.done && p.nwords <= DEPTH) len = 8'(p.nwords);
`endif
        return {len, 8'h00, 4'(YID), 4'(XID), p.dy, p.dx};
    endfunction

    always @(negedge noc_clk) begin
        if (!noc_rst_n) begin
            check("rst_in_ready", bus.in_ready, 0);
            pkt_q.delete();
            word_q.delete();
            occ      = 0;
            in_pkt   = 0;
            hdr_done = 0;
            exp_cnt  = '0;
            hold     = 0;
            rst_prev = 0;
        end else begin
            if (!rst_prev) begin
                check("rst_valid",  bus.sender_valid, 0);
                check("rst_header", bus.sender_is_header, 0);
                check("rst_tail",   bus.sender_is_tail, 0);
                check("rst_flit",   bus.sender_flit, 0);
                check("rst_cnt",    sent_pkt_cnt, 0);
            end
            rst_prev = 1;
            check("pkt_cnt", sent_pkt_cnt, exp_cnt);
            check("in_ready", bus.in_ready, occ < DEPTH);
            if (hold) begin
                check("hold_valid",  bus.sender_valid, 1);
                check("hold_flit",   bus.sender_flit, hold_flit);
                check("hold_header", bus.sender_is_header, hold_hdr);
                check("hold_tail",   bus.sender_is_tail, hold_tail);
            end
            if (bus.sender_valid && bus.sender_ready) begin
                if (pkt_q.size() == 0) begin
                    check("spurious_flit", bus.sender_valid, 0);
                end else if (!hdr_done) begin
                    check("hdr_flag", bus.sender_is_header, 1);
                    check("hdr_tail", bus.sender_is_tail, 0);
                    check("hdr_flit", bus.sender_flit, exp_header(pkt_q[0]));
`ifdef NOC_INJ_LEN_FIELD_EN
                    check("hdr_store_fwd", pkt_q[0].done || pkt_q[0].nwords >= DEPTH, 1);
`endif
                    hdr_done = 1;
                end else if (word_q.size() == 0) begin
                    check("body_underrun", bus.sender_valid, 0);
                end else begin
                    word_t w;
                    w = word_q.pop_front();
                    check("body_flag", bus.sender_is_header, 0);
                    check("body_flit", bus.sender_flit, w.data);
                    check("body_tail", bus.sender_is_tail, w.last);
                    occ--;
                    if (w.last) begin
                        void'(pkt_q.pop_front());
                        hdr_done = 0;
                        exp_cnt  = exp_cnt + 8'd1;
                    end
                end
            end
            hold      = bus.sender_valid && !bus.sender_ready;
            hold_flit = bus.sender_flit;
            hold_hdr  = bus.sender_is_header;
            hold_tail = bus.sender_is_tail;
            if (bus.in_valid && bus.in_ready) begin
                pkt_t p;
                word_t w;
                if (!in_pkt) begin
                    p.dx = bus.in_dest_x;
                    p.dy = bus.in_dest_y;
                    p.nwords = 0;
                    p.done = 0;
                    pkt_q.push_back(p);
                    in_pkt = 1;
                end
                p = pkt_q.pop_back();
                p.nwords++;
                if (bus.in_last) begin
                    p.done = 1;
                    in_pkt = 0;
                end
                pkt_q.push_back(p);
                w.data = bus.in_data;
                w.last = bus.in_last;
                word_q.push_back(w);
                occ++;
            end
        end
    end

    // Router backpressure: 0 stalled, 1 always ready, 2 random, 3 alternating.
    int   ready_mode = 0;
    logic rdy_r = 1'b0;
    always @(posedge noc_clk) begin
        #1;
        case (ready_mode)
            0:       rdy_r = 1'b0;
            1:       rdy_r = 1'b1;
            2:       rdy_r = ($urandom_range(0, 99) < 60);
            default: rdy_r = !rdy_r;
        endcase
        bus.sender_ready = rdy_r;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge noc_clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic l, input logic [CW-1:0] dx,
                             input logic [CW-1:0] dy);
        int waited;
        waited = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.in_dest_x = dx;
        bus.in_dest_y = dy;
        @(negedge noc_clk);
        while (!bus.in_ready && waited < 2000) begin
            @(negedge noc_clk);
            waited++;
        end
        if (!bus.in_ready) check("push_stall", bus.in_ready, 1);
        @(posedge noc_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_pkt(input int len, input logic [CW-1:0] dx, input logic [CW-1:0] dy,
                            input logic [DW-1:0] base, input int gap_max);
        for (int i = 0; i < len; i++) begin
            push_word(base + DW'(i), i == len - 1, dx, dy);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((pkt_q.size() != 0 || in_pkt) && n < budget) begin
            @(negedge noc_clk);
            n++;
        end
        check("drain", pkt_q.size(), 0);
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_v[5];
        int exp_h[5];
        int exp_t[5];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_dest_x = '0;
        bus.in_dest_y = '0;
        noc_rst_n     = 1'b0;
        idle(3);
        noc_rst_n = 1'b1;
        ready_mode = 1;
        idle(2);

        // 3-word packet to (1,1), router always ready, with minimum-latency timing.
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA1;
        bus.in_last   = 1'b0;
        bus.in_dest_x = 4'd1;
        bus.in_dest_y = 4'd1;
        @(negedge noc_clk);
        check("t1_in_ready", bus.in_ready, 1);
        @(posedge noc_clk); #1;
        bus.in_data = 32'hA2;
        @(negedge noc_clk);
        check("t1_lat_n1", bus.sender_valid, 0);
        @(posedge noc_clk); #1;
        bus.in_data = 32'hA3;
        bus.in_last = 1'b1;
        @(negedge noc_clk);
`ifdef NOC_INJ_LEN_FIELD_EN
        check("t1_lat_sf", bus.sender_valid, 0);
`else
        check("t1_lat_n2", bus.sender_valid, 1);
        check("t1_hdr", bus.sender_flit, 32'h0000_6311);
`endif
        @(posedge noc_clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        wait_drain(200);
        check("t1_cnt", sent_pkt_cnt, 8'd1);

        // Same packet under alternating backpressure.
        ready_mode = 3;
        send_pkt(3, 4'd1, 4'd1, 32'hA1, 0);
        wait_drain(200);
        check("t2_cnt", sent_pkt_cnt, 8'd2);

        // Fill the FIFO with a 10-word packet while the router stalls.
        ready_mode = 0;
        for (int i = 0; i < 8; i++) push_word(32'hB0 + 32'(i), 1'b0, 4'd2, 4'd3);
        @(negedge noc_clk);
        check("t3_full", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hB8;
        repeat (3) begin
            @(negedge noc_clk);
            check("t3_refuse", bus.in_ready, 0);
        end
        ready_mode = 1;
        push_word(32'hB8, 1'b0, 4'd2, 4'd3);
        push_word(32'hB9, 1'b1, 4'd2, 4'd3);
        wait_drain(300);

        // 5-word packet whose last word enters 4 cycles after the first.
        send_pkt(5, 4'd7, 4'd2, 32'hE0, 0);
        wait_drain(200);

        // Back-to-back one-word packets: header, tail, one idle cycle, header, tail.
        ready_mode = 0;
        push_word(32'hC1, 1'b1, 4'd0, 4'd1);
        push_word(32'hC2, 1'b1, 4'd1, 4'd0);
        idle(3);
        ready_mode = 1;
        @(posedge noc_clk); #2;
        exp_v = '{1, 1, 0, 1, 1};
        exp_h = '{1, 0, 0, 1, 0};
        exp_t = '{0, 1, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            @(negedge noc_clk);
            check("t4_valid", bus.sender_valid, exp_v[i]);
            if (exp_v[i] == 1) begin
                check("t4_header", bus.sender_is_header, exp_h[i]);
                check("t4_tail", bus.sender_is_tail, exp_t[i]);
            end
            if (i == 0) check("t4_dest_a", bus.sender_flit[7:0], 8'h10);
            if (i == 3) check("t4_dest_b", bus.sender_flit[7:0], 8'h01);
        end
        @(posedge noc_clk); #1;
        wait_drain(100);

        // One-cycle reset in the middle of a packet body.
        ready_mode = 0;
        for (int i = 0; i < 4; i++) push_word(32'hD0 + 32'(i), 1'b0, 4'd4, 4'd5);
        ready_mode = 1;
        repeat (4) @(negedge noc_clk);
        @(posedge noc_clk); #1;
        noc_rst_n = 1'b0;
        @(posedge noc_clk); #1;
        noc_rst_n = 1'b1;
        @(negedge noc_clk);
        check("t5_valid", bus.sender_valid, 0);
        check("t5_cnt", sent_pkt_cnt, 0);
        check("t5_empty", bus.in_ready, 1);
        @(posedge noc_clk); #1;
        send_pkt(2, 4'd6, 4'd9, 32'hF0, 0);
        wait_drain(200);
        check("t5_cnt_after", sent_pkt_cnt, 8'd1);

        // Random traffic under random backpressure.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 12), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     $urandom(), 2);
            idle($urandom_range(0, 3));
        end
        wait_drain(5000);
        check("final_cnt", sent_pkt_cnt, 8'd41);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Local-port network interface that sits directly upstream of a mesh router's local input port.
- Accepts a word stream from a core: a payload word per beat, with a last marker and a per-packet destination.
- Buffers payload words in an internal FIFO and emits the router flit protocol: one header flit, then payload body flits, with the final flit marked as tail.
- Replaces the self-generating test node when real traffic sources are attached.

Parameters:
- DATA_WIDTH, 32, flit/payload width; must be at least 4*COORD_W+8.
- COORD_W, 4, width of each X/Y coordinate field.
- X_ID, 0, this node's X coordinate, inserted as source X.
- Y_ID, 0, this node's Y coordinate, inserted as source Y.
- FIFO_DEPTH, 8, payload FIFO entries; power of two, at least 2.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  reset.
- in_valid  in  1  core word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  DATA_WIDTH  payload word.
- in_last  in  1  final word of packet.
- in_dest_x  in  COORD_W  destination X; sampled only on a packet's first word.
- in_dest_y  in  COORD_W  destination Y; sampled only on a packet's first word.
- sender_valid  out  1  flit valid to router.
- sender_ready  in  1  router accepts flit.
- sender_flit  out  DATA_WIDTH  flit.
- sender_is_header  out  1  flit is header.
- sender_is_tail  out  1  flit is tail.
- sent_pkt_cnt  out  8  count of packets whose tail was accepted; wraps 255 to 0.

Behaviour:
- Clock and reset: one clock, noc_clk; reset noc_rst_n is synchronous, active-low.
- Reset values: FSM in IDLE, FIFO empty, sender_valid=0, sender_is_header=0, sender_is_tail=0, sender_flit=0, sent_pkt_cnt=0, in_ready=0 while reset is asserted.
- Reset mid-packet: the partial packet and the FIFO contents are discarded, with no tail emitted.
- Input side:
  - in_ready = !fifo_full.
  - A word is written when in_valid && in_ready.
  - FIFO entry = {data, last, first, dest_x, dest_y}.
  - first is set on the first accepted word after reset or after a word with last=1.
  - dest is latched on the first word and copied into every entry of that packet.
- Simultaneous push and pop when full: the push is refused, because in_ready is low.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- Header flit layout:
  - [COORD_W-1:0] dest_x.
  - [2C-1:C] dest_y.
  - [3C-1:2C] src_x=X_ID.
  - [4C-1:3C] src_y=Y_ID.
  - [DATA_WIDTH-1:DATA_WIDTH-8] length field; zero unless the optional feature is enabled.
  - All remaining bits zero.
- FSM (outputs are registered):
  - IDLE: when the FIFO is not empty (and the header release condition holds), load the header flit from the head entry's dest, set sender_valid=1 and sender_is_header=1, go to HDR. No pop.
  - HDR: hold the flit until sender_ready. On acceptance, present the head payload (is_header=0, is_tail=head.last) and go to BODY, or stay in HDR with valid=0 if the FIFO is empty. The FIFO cannot be empty here, because the head exists.
  - BODY: on sender_valid && sender_ready, pop the FIFO.
    - If the popped word was last: increment sent_pkt_cnt, then go to IDLE with valid=0.
    - Else, if the next entry is present, present it next cycle; otherwise drop valid and wait (bubble) until a word arrives.
- Flit output is stable: flit, is_header and is_tail do not change while sender_valid=1 && !sender_ready.
- Minimum latency: first word written at cycle N, header valid at N+2, first body flit valid the cycle after header acceptance.
- Back-to-back packets:
  - IDLE lasts exactly one cycle between a tail acceptance and the next header becoming valid.
  - A one-word packet is a header followed by a single body flit with is_tail=1.
- Pointers wrap modulo FIFO_DEPTH. Full is tracked by a count of 0..FIFO_DEPTH.

Optional Feature:
- Macro: NOC_INJ_LEN_FIELD_EN.
- When defined:
  - Store-and-forward operation. IDLE releases the header only when the FIFO holds the packet's last word, or when the FIFO is full.
  - Length field = number of payload words, 1..FIFO_DEPTH.
  - Full-without-last case: the header is released with length 0, meaning unknown length, and the packet then streams cut-through.
- When undefined: the header is released as soon as the head is present, the length field is 0, and the design is pure cut-through.

Test Plan:
1. Reset, X_ID=0, Y_ID=0, 3-word packet 0xA1,0xA2,0xA3 to (1,1), sender_ready=1 -> header 0x00000011, then 0xA1, 0xA2, 0xA3; tail only on 0xA3; sent_pkt_cnt=1.
2. Same packet with sender_ready toggling 1,0,1,0 -> each flit held stable while ready=0; no duplicate or lost flits; tail appears once.
3. Push 8 words with no last while sender_ready=0 (FIFO_DEPTH=8) -> in_ready=0 after the 8th word; a 9th in_valid beat is not accepted.
4. One-word packets back-to-back to (0,1) and (1,0) -> header, tail, 1 idle cycle, header, tail; the headers carry dest 0x10 and 0x01 in the low byte.
5. Assert noc_rst_n=0 for 1 cycle mid-body -> next cycle sender_valid=0, the FIFO is empty, sent_pkt_cnt=0; a following new packet is emitted correctly.
6. With NOC_INJ_LEN_FIELD_EN, a 5-word packet whose last word enters 4 cycles after the first -> header is not valid before the last word is written; header[31:24]=5. A 10-word packet gives header length 0.
